// File: rtl/imem_port_arbiter.sv
// Arbitrates a single-port synchronous-read instruction RAM between CPU fetch (read)
// and the program loader (write). Fetch wins unless the loader has been starved.
module imem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [31:0]       f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  input  logic              l_req,
  input  logic [31:0]       l_addr,
  input  logic [31:0]       l_wdata,
  output logic              l_gnt,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata,
  output logic [3:0]        starve_cnt_o
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              f_rvalid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] f_word, l_word;
  logic              force_l;

  // Byte offset and bits above the array are dropped: addresses wrap silently.
  assign f_word = f_addr[ADDR_W+1:2];
  assign l_word = l_addr[ADDR_W+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{f_addr[31:ADDR_W+2], f_addr[1:0],
                              l_addr[31:ADDR_W+2], l_addr[1:0]};

  assign force_l = l_req && (starve_cnt_q == LIMIT);

  // Grants are held off during reset so no write can reach the RAM.
  always_comb begin
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (rst_n) begin
      if (f_req && !force_l) begin
        f_gnt = 1'b1;
      end else if (l_req) begin
        l_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    m_en    = f_gnt | l_gnt;
    m_we    = l_gnt;
    m_addr  = addr_q;
    m_wdata = wdata_q;
    if (f_gnt) begin
      m_addr = f_word;
    end else if (l_gnt) begin
      m_addr  = l_word;
      m_wdata = l_wdata;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!l_req || l_gnt) begin
      starve_cnt_d = 4'd0;
    end else if (f_gnt && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 4'd0;
      f_rvalid_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      f_rvalid_q   <= f_gnt;
      addr_q       <= m_addr;
      wdata_q      <= m_wdata;
    end
  end

  assign f_rvalid     = f_rvalid_q;
  assign f_rdata      = m_rdata;
  assign starve_cnt_o = starve_cnt_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural 256-word synchronous RAM.
module tb_imem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, l_req;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_gnt, f_rvalid, l_gnt, m_en, m_we;
  logic [31:0] f_rdata, m_wdata;
  logic [31:0] m_rdata = 32'h0;
  logic [7:0]  m_addr;
  logic [3:0]  starve_cnt_o;
  logic [31:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.ADDR_W(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_addr(l_addr), .l_wdata(l_wdata), .l_gnt(l_gnt),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .starve_cnt_o(starve_cnt_o)
  );

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'h100 + 32'(i);
  end

  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) mem[m_addr] <= m_wdata;
      else      m_rdata     <= mem[m_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        f_req;
    logic [31:0] f_addr;
    logic        l_req;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        e_fg;
    logic        e_lg;
    logic [7:0]  e_addr;
    logic [3:0]  e_cnt;
    logic        e_rv;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tv [29];

  function automatic vec_t v(logic fr, logic [31:0] fa, logic lr, logic [31:0] la,
                             logic [31:0] lw, logic fg, logic lg, logic [7:0] ad,
                             logic [3:0] cnt, logic rv, logic [31:0] rd);
    vec_t r;
    r.f_req = fr; r.f_addr = fa; r.l_req = lr; r.l_addr = la; r.l_wdata = lw;
    r.e_fg = fg; r.e_lg = lg; r.e_addr = ad; r.e_cnt = cnt; r.e_rv = rv; r.e_rd = rd;
    return r;
  endfunction

  initial begin
    // Fetch stream over preloaded data, including the last word.
    tv[0]  = v(1, 32'h000, 0, 0, 0, 1, 0, 8'd0,   0, 0, 0);
    tv[1]  = v(1, 32'h004, 0, 0, 0, 1, 0, 8'd1,   0, 1, 32'h100);
    tv[2]  = v(1, 32'h008, 0, 0, 0, 1, 0, 8'd2,   0, 1, 32'h101);
    tv[3]  = v(1, 32'h3FC, 0, 0, 0, 1, 0, 8'd255, 0, 1, 32'h102);
    tv[4]  = v(0, 0,       0, 0, 0, 0, 0, 8'd0,   0, 1, 32'h1FF);
    tv[5]  = v(0, 0,       0, 0, 0, 0, 0, 8'd0,   0, 0, 0);
    // Both requesting: f,f,f,f,l,f,f,f,f,l.
    tv[6]  = v(1, 32'h20, 1, 32'h80, 32'h55, 1, 0, 8'd8,  0, 0, 0);
    tv[7]  = v(1, 32'h20, 1, 32'h80, 32'h55, 1, 0, 8'd8,  1, 1, 32'h108);
    tv[8]  = v(1, 32'h20, 1, 32'h80, 32'h55, 1, 0, 8'd8,  2, 1, 32'h108);
    tv[9]  = v(1, 32'h20, 1, 32'h80, 32'h55, 1, 0, 8'd8,  3, 1, 32'h108);
    tv[10] = v(1, 32'h20, 1, 32'h80, 32'h55, 0, 1, 8'd32, 4, 1, 32'h108);
    tv[11] = v(1, 32'h20, 1, 32'h80, 32'h55, 1, 0, 8'd8,  0, 0, 0);
    tv[12] = v(1, 32'h20, 1, 32'h80, 32'h55, 1, 0, 8'd8,  1, 1, 32'h108);
    tv[13] = v(1, 32'h20, 1, 32'h80, 32'h55, 1, 0, 8'd8,  2, 1, 32'h108);
    tv[14] = v(1, 32'h20, 1, 32'h80, 32'h55, 1, 0, 8'd8,  3, 1, 32'h108);
    tv[15] = v(1, 32'h20, 1, 32'h80, 32'h55, 0, 1, 8'd32, 4, 1, 32'h108);
    tv[16] = v(0, 0,      0, 0,      0,      0, 0, 8'd0,  0, 0, 0);
    // Write then read next cycle, low address bits ignored.
    tv[17] = v(0, 0,      1, 32'h10, 32'hDEADBEEF, 0, 1, 8'd4, 0, 0, 0);
    tv[18] = v(1, 32'h12, 0, 0,      0,            1, 0, 8'd4, 0, 0, 0);
    tv[19] = v(0, 0,      0, 0,      0,            0, 0, 8'd0, 0, 1, 32'hDEADBEEF);
    // Address wrap: byte 0x400 is word 0.
    tv[20] = v(0, 0,      1, 32'h400, 32'hA5A5A5A5, 0, 1, 8'd0, 0, 0, 0);
    tv[21] = v(1, 32'h0,  0, 0,       0,            1, 0, 8'd0, 0, 0, 0);
    tv[22] = v(0, 0,      0, 0,       0,            0, 0, 8'd0, 0, 1, 32'hA5A5A5A5);
    // Dropping l_req clears the starvation count.
    tv[23] = v(1, 32'h20, 1, 32'h80, 32'h55, 1, 0, 8'd8, 0, 0, 0);
    tv[24] = v(1, 32'h20, 1, 32'h80, 32'h55, 1, 0, 8'd8, 1, 1, 32'h108);
    tv[25] = v(1, 32'h20, 0, 32'h80, 32'h55, 1, 0, 8'd8, 2, 1, 32'h108);
    tv[26] = v(1, 32'h20, 1, 32'h80, 32'h55, 1, 0, 8'd8, 0, 1, 32'h108);
    tv[27] = v(0, 0,      0, 0,      0,      0, 0, 8'd0, 1, 1, 32'h108);
    tv[28] = v(0, 0,      0, 0,      0,      0, 0, 8'd0, 0, 0, 0);

    // Reset with both requests asserted.
    rst_n = 1'b0; f_req = 1'b1; l_req = 1'b1;
    f_addr = 32'h0; l_addr = 32'h0; l_wdata = 32'h0;
    #12;
    chk("rst_rvalid", 32'(f_rvalid), 32'h0);
    chk("rst_cnt",    32'(starve_cnt_o), 32'h0);
    chk("rst_m_en",   32'(m_en), 32'h0);
    chk("rst_l_gnt",  32'(l_gnt), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    #1;
    chk("rel_f_gnt", 32'(f_gnt), 32'h1);
    chk("rel_l_gnt", 32'(l_gnt), 32'h0);
    f_req = 1'b0; l_req = 1'b0;

    for (int i = 0; i < 29; i++) begin
      @(posedge clk); #1;
      f_req = tv[i].f_req; f_addr = tv[i].f_addr;
      l_req = tv[i].l_req; l_addr = tv[i].l_addr; l_wdata = tv[i].l_wdata;
      #2;
      chk($sformatf("v%0d_f_gnt", i),  32'(f_gnt), 32'(tv[i].e_fg));
      chk($sformatf("v%0d_l_gnt", i),  32'(l_gnt), 32'(tv[i].e_lg));
      chk($sformatf("v%0d_m_en", i),   32'(m_en),  32'(tv[i].e_fg | tv[i].e_lg));
      chk($sformatf("v%0d_cnt", i),    32'(starve_cnt_o), 32'(tv[i].e_cnt));
      chk($sformatf("v%0d_rvalid", i), 32'(f_rvalid), 32'(tv[i].e_rv));
      if (tv[i].e_fg | tv[i].e_lg) begin
        chk($sformatf("v%0d_m_we", i),   32'(m_we),   32'(tv[i].e_lg));
        chk($sformatf("v%0d_m_addr", i), 32'(m_addr), 32'(tv[i].e_addr));
      end
      if (tv[i].e_lg) chk($sformatf("v%0d_m_wdata", i), m_wdata, tv[i].l_wdata);
      if (tv[i].e_rv) chk($sformatf("v%0d_f_rdata", i), f_rdata, tv[i].e_rd);
    end

    // Asynchronous reset right after a fetch grant, loader still asking.
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h20; l_req = 1'b1; l_addr = 32'h40; l_wdata = 32'hBAD;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_cnt",    32'(starve_cnt_o), 32'h2);
    chk("pre_rvalid", 32'(f_rvalid), 32'h1);
    f_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rvalid", 32'(f_rvalid), 32'h0);
    chk("mid_cnt",    32'(starve_cnt_o), 32'h0);
    chk("mid_l_gnt",  32'(l_gnt), 32'h0);
    chk("mid_m_we",   32'(m_we), 32'h0);
    @(posedge clk); #1;
    chk("mid_no_write", mem[16], 32'h110);
    rst_n = 1'b1; l_req = 1'b0;
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
Shares one single-port, synchronous-read instruction memory between two requesters: the CPU fetch stage (read-only) and the program loader (write-only).
- Fetch has priority.
- A starvation counter guarantees the loader one grant after STARVE_LIMIT consecutive fetch wins while the loader is waiting.
- Sits between the IF stage and the writable instruction RAM; it produces the RAM control signals and the fetch read-valid timing.

Parameters:
ADDR_W, 8, word-address width of the memory (256 words).
STARVE_LIMIT, 4, consecutive fetch grants tolerated while l_req is pending; legal range 1..15.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
f_req  input  1  fetch read request, valid this cycle.
f_addr  input  32  fetch byte address.
f_gnt  output  1  fetch request accepted this cycle (combinational).
f_rvalid  output  1  f_rdata valid; registered, one cycle after f_gnt.
f_rdata  output  32  fetch read data (driven from m_rdata).
l_req  input  1  loader write request.
l_addr  input  32  loader byte address.
l_wdata  input  32  loader write data.
l_gnt  output  1  loader write performed this cycle (combinational).
m_en  output  1  memory enable.
m_we  output  1  memory write enable.
m_addr  output  ADDR_W  memory word address.
m_wdata  output  32  memory write data.
m_rdata  input  32  memory read data, valid the cycle after m_en & !m_we.
starve_cnt_o  output  4  current starvation count (debug).

Behaviour:
Clock and reset:
- Clock is clk, rising edge. Reset is rst_n: asynchronous assert, active-low.

Reset values:
- f_rvalid=0 and starve_cnt=0.
- Combinational outputs follow from these: with no requests, f_gnt=0, l_gnt=0, m_en=0, m_we=0.

Addressing:
- Word address is addr[ADDR_W+1:2].
- addr[1:0] is ignored, with no misalignment error.
- Bits above ADDR_W+1 are ignored, so addresses wrap modulo 2^ADDR_W words.

Grant decision (combinational, per cycle; at most one grant):
- Only f_req: f_gnt=1.
- Only l_req: l_gnt=1.
- Both, starve_cnt < STARVE_LIMIT: f_gnt=1.
- Both, starve_cnt == STARVE_LIMIT: l_gnt=1 (forced loader slot).
- Neither: no grant, m_en=0.

Memory drive:
- On f_gnt: m_en=1, m_we=0, m_addr=f word addr.
- On l_gnt: m_en=1, m_we=1, m_addr=l word addr, m_wdata=l_wdata.
- Otherwise m_en=0; m_addr and m_wdata hold their last value (don't-care).

Starvation counter (registered):
- Increments when f_gnt & l_req.
- Clears to 0 when l_gnt, or when l_req=0.
- Saturates at STARVE_LIMIT.

Read timing:
- f_rvalid <= f_gnt, so read latency is exactly 1 cycle.
- f_rdata = m_rdata combinationally; it is valid only when f_rvalid=1.
- Back-to-back fetch grants give one f_rvalid per cycle (full throughput).

Requester handshake:
- Requesters hold req, addr and data stable until their grant.
- A request without a grant is not recorded; no queueing inside the block.

Write/read ordering:
- A write in cycle N is visible to a fetch granted in cycle N+1 or later.
- A fetch granted in cycle N-1 returns the old data.

Reset mid-operation:
- A pending f_rvalid is dropped and starve_cnt is cleared.
- No partial write occurs, since writes are single-cycle.

Test Plan:
- Reset: hold rst_n=0 with f_req=l_req=1 -> f_rvalid=0, starve_cnt_o=0. On release, the first cycle gives f_gnt=1 and l_gnt=0.
- Fetch stream: f_req=1 with f_addr=0x00,0x04,0x08,0x3FC on consecutive cycles, memory preloaded with mem[i]=i+0x100.
  - Expect f_rvalid=1 one cycle after each grant.
  - Expect f_rdata=0x100,0x101,0x102,0x1FF in order.
- Starvation (STARVE_LIMIT=4): f_req=1 and l_req=1 held continuously.
  - Expected grant pattern: f,f,f,f,l,f,f,f,f,l.
  - starve_cnt_o sequence: 0,1,2,3,4,0,1,...
  - m_we=1 only on the loader slots.
- Write-then-read: loader writes 0xDEADBEEF to addr 0x10 in cycle N (f_req=0); fetch of addr 0x12 in cycle N+1 -> f_rdata=0xDEADBEEF in cycle N+2 (low bits ignored).
- Wrap: l_addr=0x400 with wdata 0xA5A5A5A5 writes word 0; fetch of 0x0 -> 0xA5A5A5A5.
- Reset mid-stream: assert rst_n=0 asynchronously mid-cycle right after an f_gnt -> f_rvalid falls immediately, starve_cnt_o=0, and no write is issued while in reset.
